// File: rtl/corner_marker_array.sv
// Cross-shaped corner markers overlaid on the raster, with a
// frame-synchronous shadow set and a blinking highlighted marker.
module corner_marker_array #(
  parameter int          N_CORNERS    = 4,
  parameter int          IDX_W        = 2,
  parameter int          ARM          = 20,
  parameter logic [29:0] COLOUR       = 30'h3FFFFFFF,
  parameter logic [29:0] SEL_COLOUR   = 30'h3FF00000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [10:0]      wr_x,
  input  logic [9:0]       wr_y,
  input  logic             wr_vis,
  input  logic [IDX_W-1:0] sel_idx,
  input  logic             blink_en,
  input  logic [10:0]      hcount,
  input  logic [9:0]       vcount,
  output logic [29:0]      pixel
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(BLINK_FRAMES - 1);
  localparam logic [11:0] A = 12'(ARM);
  localparam logic [IDX_W:0] NC = (IDX_W + 1)'(N_CORNERS);

  logic [10:0] sx [N_CORNERS];
  logic [9:0]  sy [N_CORNERS];
  logic        sv [N_CORNERS];
  logic [10:0] ax [N_CORNERS];
  logic [9:0]  ay [N_CORNERS];
  logic        av [N_CORNERS];

  logic [CW-1:0] cnt;
  logic          phase;
  logic          wok;
  logic [N_CORNERS-1:0] hit;
  logic          selhit;
  logic [29:0]   nxt;

  assign wok = wr_en && ({1'b0, wr_idx} < NC);

  // A write in the tick cycle bypasses straight into the active set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CORNERS; i++) begin
        sx[i] <= '0;
        sy[i] <= '0;
        sv[i] <= 1'b0;
        ax[i] <= '0;
        ay[i] <= '0;
        av[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_CORNERS; i++) begin
        if (wok && wr_idx == IDX_W'(i)) begin
          sx[i] <= wr_x;
          sy[i] <= wr_y;
          sv[i] <= wr_vis;
        end
        if (frame_tick) begin
          if (wok && wr_idx == IDX_W'(i)) begin
            ax[i] <= wr_x;
            ay[i] <= wr_y;
            av[i] <= wr_vis;
          end else begin
            ax[i] <= sx[i];
            ay[i] <= sy[i];
            av[i] <= sv[i];
          end
        end
      end
    end
  end

  // 12-bit compares so arms clip at the screen edges instead of wrapping.
  always_comb begin
    hit    = '0;
    selhit = 1'b0;
    for (int i = 0; i < N_CORNERS; i++) begin
      hit[i] = av[i] && (
        ((vcount == ay[i]) &&
         (({1'b0, hcount} + A) > {1'b0, ax[i]}) &&
         ({1'b0, hcount} < ({1'b0, ax[i]} + A))) ||
        ((hcount == ax[i]) &&
         (({2'b0, vcount} + A) > {2'b0, ay[i]}) &&
         ({2'b0, vcount} < ({2'b0, ay[i]} + A))));
      if (sel_idx == IDX_W'(i))
        selhit = hit[i];
    end
  end

  always_comb begin
    nxt = '0;
    if (selhit && phase)
      nxt = SEL_COLOUR;
    else if (|hit)
      nxt = COLOUR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b1;
      pixel <= '0;
    end else begin
      pixel <= nxt;
      if (!blink_en) begin
        cnt   <= '0;
        phase <= 1'b1;
      end else if (frame_tick) begin
        if (cnt == CMAX) begin
          cnt   <= '0;
          phase <= ~phase;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_corner_marker_array.sv
// Directed bench for corner_marker_array: visibility, arm extent,
// clipping, blink, priority, tick/write bypass and async reset.
module tb_corner_marker_array;

  localparam logic [29:0] C = 30'h3FFFFFFF;
  localparam logic [29:0] S = 30'h3FF00000;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        frame_tick = 0;
  logic        wr_en = 0;
  logic [1:0]  wr_idx = 0;
  logic [10:0] wr_x = 0;
  logic [9:0]  wr_y = 0;
  logic        wr_vis = 0;
  logic [1:0]  sel_idx = 2'd3;
  logic        blink_en = 0;
  logic [10:0] hcount = 0;
  logic [9:0]  vcount = 0;
  logic [29:0] pixel;

  int ntests = 0;
  int nfail = 0;

  corner_marker_array #(
    .N_CORNERS(3), .IDX_W(2), .ARM(20),
    .COLOUR(C), .SEL_COLOUR(S), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
    .wr_vis(wr_vis), .sel_idx(sel_idx), .blink_en(blink_en),
    .hcount(hcount), .vcount(vcount), .pixel(pixel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [29:0] exp);
    ntests++;
    assert (pixel === exp) else begin
      nfail++;
      $error("FAIL %s got %h exp %h", tag, pixel, exp);
    end
  endtask

  task automatic px(input int h, input int v, input logic [29:0] exp,
                    input string tag);
    hcount = 11'(h);
    vcount = 10'(v);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  task automatic tick();
    frame_tick = 1;
    @(posedge clk);
    #1;
    frame_tick = 0;
  endtask

  task automatic wr(input int i, input int x, input int y,
                    input logic vis);
    wr_en = 1;
    wr_idx = 2'(i);
    wr_x = 11'(x);
    wr_y = 10'(y);
    wr_vis = vis;
    @(posedge clk);
    #1;
    wr_en = 0;
  endtask

  initial begin
    #2;
    chk("reset", 30'h0);
    #10 rst_n = 1;
    @(posedge clk);
    #1;

    wr(0, 100, 50, 1);
    px(100, 50, 30'h0, "no_tick");
    tick();
    px(100, 50, C, "after_tick");

    px(81, 50, C, "h81");
    px(119, 50, C, "h119");
    px(80, 50, 30'h0, "h80");
    px(120, 50, 30'h0, "h120");
    px(100, 31, C, "v31");
    px(100, 69, C, "v69");
    px(100, 30, 30'h0, "v30");
    px(100, 70, 30'h0, "v70");

    wr(0, 5, 3, 1);
    tick();
    for (int h = 0; h <= 24; h++) px(h, 3, C, "clip_lo");
    for (int h = 2040; h <= 2047; h++) px(h, 3, 30'h0, "clip_hi");
    px(5, 1023, 30'h0, "clip_v1023");

    wr(0, 100, 50, 1);
    tick();
    sel_idx = 2'd0;
    blink_en = 1;
    @(posedge clk);
    #1;
    px(100, 50, S, "blink_f0");
    tick();
    px(100, 50, S, "blink_f1");
    tick();
    px(100, 50, C, "blink_f2");
    tick();
    px(100, 50, C, "blink_f3");
    tick();
    px(100, 50, S, "blink_f4");
    tick();
    tick();
    px(100, 50, C, "blink_f6");
    blink_en = 0;
    @(posedge clk);
    #1;
    px(100, 50, S, "blink_off");

    wr(0, 200, 100, 1);
    wr(1, 210, 100, 1);
    tick();
    sel_idx = 2'd1;
    px(205, 100, S, "ovl_sel1");
    sel_idx = 2'd3;
    px(205, 100, C, "ovl_sel3");
    sel_idx = 2'd2;
    px(205, 100, C, "ovl_sel2_invis");
    sel_idx = 2'd3;
    wr(3, 300, 300, 1);
    tick();
    px(205, 100, C, "bad_idx_keep");
    px(300, 300, 30'h0, "bad_idx_none");

    wr_en = 1;
    wr_idx = 2'd2;
    wr_x = 11'd300;
    wr_y = 10'd300;
    wr_vis = 1;
    frame_tick = 1;
    @(posedge clk);
    #1;
    wr_en = 0;
    frame_tick = 0;
    px(300, 300, C, "wr_tick");
    px(300, 300, C, "hold_line");
    #3 rst_n = 0;
    #1;
    chk("async_rst", 30'h0);
    #3 rst_n = 1;
    tick();
    px(300, 300, 30'h0, "cleared2");
    px(200, 100, 30'h0, "cleared0");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/corner_marker_array.md
Name: corner_marker_array

Overview:
- Draws up to N_CORNERS cross-shaped corner markers over the video raster, for example the four user-placed quad corners used by rectilinearisation.
- Marker positions are written through a simple write port into shadow registers. They are copied to the active set only at frame start, so markers never tear mid-frame.
- One selected corner is drawn in a highlight colour and can blink at a frame-counted rate.
- Pixel output is registered, with one-cycle latency, for merging into the pixel mixer.

Parameters:
- N_CORNERS, 4, number of markers; must satisfy N_CORNERS <= 2**IDX_W.
- IDX_W, 2, width of corner index ports.
- ARM, 20, half-length of each marker arm in pixels; the arm spans centre ±(ARM-1).
- COLOUR, 30'h3FFFFFFF, 30-bit colour for unselected markers.
- SEL_COLOUR, 30'h3FF00000, 30-bit colour for the selected marker.
- BLINK_FRAMES, 30, number of frames per blink half-period; must be >= 1.

Ports:
- clk, in, 1, pixel clock.
- rst_n, in, 1, asynchronous active-low reset.
- frame_tick, in, 1, one-cycle pulse at frame start (during vertical blanking).
- wr_en, in, 1, write strobe for a shadow marker entry.
- wr_idx, in, IDX_W, index of the marker to write.
- wr_x, in, 11, marker centre x.
- wr_y, in, 10, marker centre y.
- wr_vis, in, 1, marker visible flag.
- sel_idx, in, IDX_W, index of the highlighted marker; sampled every cycle.
- blink_en, in, 1, enables blinking of the selected marker.
- hcount, in, 11, current raster x.
- vcount, in, 10, current raster y.
- pixel, out, 30, marker colour, or 0 where no marker is drawn.

Behaviour:
- Reset (rst_n low, asynchronous): all shadow and active x, y and vis cleared to 0; frame counter = 0; blink_phase = 1; pixel = 0. Nothing is drawn until markers are written and a frame_tick occurs.
- Write: on a rising edge with wr_en=1 and wr_idx < N_CORNERS, shadow[wr_idx] <= {wr_x, wr_y, wr_vis}. If wr_idx >= N_CORNERS the write is ignored and no state changes.
- Transfer: on a rising edge with frame_tick=1, every active entry <= shadow entry.
  - If wr_en and frame_tick occur in the same cycle, the transferred value includes that write.
- Hit test per active entry i, using 12-bit zero-extended arithmetic with no wrap-around:
  - hline_i = (vcount == y_i) and (hcount + ARM > x_i) and (hcount < x_i + ARM).
  - vline_i = (hcount == x_i) and (vcount + ARM > y_i) and (vcount < y_i + ARM).
  - hit_i = vis_i and (hline_i or vline_i).
  - Markers near 0 or near the screen edge are clipped correctly; no spurious pixels appear at the opposite edge.
- Colour select, in priority order:
  - If the selected entry hits and blink_phase=1, output SEL_COLOUR.
  - Otherwise, if any entry hits, output COLOUR. This includes the selected entry when blink_phase=0; it drops to normal colour and does not vanish.
  - Otherwise output 0.
  - sel_idx >= N_CORNERS means no marker is highlighted.
- Latency: pixel at edge t+1 reflects hcount/vcount/sel_idx sampled at edge t and the active registers as they were before edge t's transfer.
- Blink:
  - While blink_en=0, frame counter is held at 0 and blink_phase is held at 1.
  - While blink_en=1, each frame_tick increments the counter. When the counter equals BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - Re-enabling blink_en starts from counter 0, phase 1.
- Reset mid-frame: pixel goes to 0 immediately (asynchronously), and all state returns to reset values.

Test Plan:
- Reset, then write idx0 = (100,50,vis=1) with no frame_tick, then raster (100,50) -> pixel stays 0. After frame_tick, the same raster point -> pixel = COLOUR one cycle after hcount = 100.
- Arm extent with marker at (100,50), sel_idx=3, vis3=0:
  - hcount 81 and 119 on vcount 50 -> COLOUR.
  - hcount 80 and 120 -> 0.
  - vcount 31 and 69 on hcount 100 -> COLOUR; vcount 30 and 70 -> 0.
- Edge clip with marker at (5,3): hcount 0..24 on vcount 3 -> COLOUR; hcount 2040..2047 -> 0; vcount 1023 on hcount 5 -> 0.
- Highlight and blink with sel_idx=0, blink_en=1, BLINK_FRAMES=2:
  - Marker pixel = SEL_COLOUR for frames 0–1, COLOUR for frames 2–3, SEL_COLOUR again for frame 4.
  - Dropping blink_en -> SEL_COLOUR steady.
- Overlap and priority:
  - Markers 0 at (200,100) and 1 at (210,100), sel_idx=1, hcount 205 on vcount 100 -> SEL_COLOUR.
  - sel_idx=3 -> COLOUR.
  - Write to wr_idx=3 with N_CORNERS=3 -> no change in output.
- Simultaneous write and frame_tick to idx2 = (300,300) -> marker drawn at (300,300) in the following frame. Asserting rst_n low mid-line -> pixel = 0 with no clock edge needed, and all markers cleared.
